// File: rtl/mbist_march_seq_if.sv
// rtl/mbist_march_seq_if.sv - Control and memory-side bundle of the March C- sequencer
//
// Signals:
//   start    : begin a test (honoured only when the sequencer is idle or done)
//   busy     : test running, including the delay-line drain
//   done     : level, high from completion until the next accepted start
//   bg_code  : {d, bg[1:0], p} word for the background decoder
//   mem_addr : memory address, aligned with the decoder's registered output
//   mem_we   : write strobe, aligned with mem_addr
//   mem_re   : read strobe, aligned with mem_addr
// Modports: master (test controller side), slave (sequencer side).
interface mbist_march_seq_if #(
    parameter int AW = 4
);
    logic          start;
    logic          busy;
    logic          done;
    logic [3:0]    bg_code;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;

    modport master (
        output start,
        input  busy, done, bg_code, mem_addr, mem_we, mem_re
    );

    modport slave (
        input  start,
        output busy, done, bg_code, mem_addr, mem_we, mem_re
    );
endinterface

// File: rtl/mbist_march_seq.sv
// rtl/mbist_march_seq.sv - March C- sequencer with per-op background code and delayed memory strobes
//
// Ports:
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : mbist_march_seq_if.slave (start in; busy, done, bg_code, mem_addr, mem_we, mem_re out)
// Parameters:
//   AW      : address width, N = 2**AW words
//   EXP_LAT : decoder latency, 1..4; delay from bg_code to mem_*
// Build option:
//   MARCH_STRIPE_BG_EN : when defined, the row-stripe background (bg=10) is run after
//                        solid and checkerboard; otherwise the test ends after checkerboard.
module mbist_march_seq #(
    parameter int AW      = 4,
    parameter int EXP_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    mbist_march_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    elem_q, elem_d;      // March element E0..E5
    logic          phase_q, phase_d;    // second op of a two-op element
    logic [AW-1:0] addr_q, addr_d;
    logic [1:0]    bg_q, bg_d;
    logic [2:0]    drain_q, drain_d;

    logic          run;
    logic          two_op;
    logic          down;
    logic          elem_end;
    logic          last_bg;
    logic          op_we;
    logic          op_re;
    logic          op_d;
    logic          op_p;

    // Delay line aligning {addr, we, re} with the decoder's registered word.
    logic [AW+1:0] dly_q [EXP_LAT];

    assign run      = (state_q == RUN);
    assign two_op   = (elem_q >= 3'd1) && (elem_q <= 3'd4);
    assign down     = (elem_q == 3'd3) || (elem_q == 3'd4);
    assign elem_end = down ? (addr_q == '0) : (addr_q == {AW{1'b1}});

`ifdef MARCH_STRIPE_BG_EN
    assign last_bg = (bg_q == 2'd2);
`else
    assign last_bg = (bg_q == 2'd1);
`endif

    // E0 is write-only, E5 read-only; two-op elements read then write.
    assign op_we = run && ((elem_q == 3'd0) || phase_q);
    assign op_re = run && !((elem_q == 3'd0) || phase_q);

    // Data value: first ops of E2/E4 read 1, second ops of E1/E3 write 1.
    assign op_d = phase_q ? ((elem_q == 3'd1) || (elem_q == 3'd3))
                          : ((elem_q == 3'd2) || (elem_q == 3'd4));

    // Solid background never inverts per word; the others alternate on addr[0].
    assign op_p = (bg_q == 2'd0) ? 1'b1 : ~addr_q[0];

    // Counters freeze when RUN ends, so the last code is held until the next start.
    assign bus.bg_code  = {op_d, bg_q, op_p};
    assign bus.busy     = (state_q == RUN) || (state_q == DRAIN);
    assign bus.done     = (state_q == DONE);
    assign bus.mem_addr = dly_q[EXP_LAT-1][AW+1:2];
    assign bus.mem_we   = dly_q[EXP_LAT-1][1];
    assign bus.mem_re   = dly_q[EXP_LAT-1][0];

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        phase_d = phase_q;
        addr_d  = addr_q;
        bg_d    = bg_q;
        drain_d = drain_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    elem_d  = 3'd0;
                    phase_d = 1'b0;
                    addr_d  = '0;
                    bg_d    = 2'd0;
                end
            end
            RUN: begin
                if (two_op && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (!elem_end) begin
                        addr_d = down ? (addr_q - AW'(1)) : (addr_q + AW'(1));
                    end else if (elem_q != 3'd5) begin
                        elem_d = elem_q + 3'd1;
                        // E3 and E4 descend, so they start from the top address.
                        addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? {AW{1'b1}} : '0;
                    end else if (!last_bg) begin
                        bg_d   = bg_q + 2'd1;
                        elem_d = 3'd0;
                        addr_d = '0;
                    end else begin
                        state_d = DRAIN;
                        drain_d = 3'(EXP_LAT - 1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 3'd0) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            elem_q  <= 3'd0;
            phase_q <= 1'b0;
            addr_q  <= '0;
            bg_q    <= 2'd0;
            drain_q <= 3'd0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            phase_q <= phase_d;
            addr_q  <= addr_d;
            bg_q    <= bg_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < EXP_LAT; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= {addr_q, op_we, op_re};
            for (int i = 1; i < EXP_LAT; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

endmodule
